// File: rtl/pu_pass_scheduler.sv
// pu_pass_scheduler: runs the oc/ic pass loop of one layer descriptor.
// Ports: clk, reset (async low), cfg_* descriptor in, pass_* PU pass
// control out, pass_done in, wb_req/wb_ack writeback handshake,
// busy/layer_done status; perf_* counters only with PU_SCHED_PERF_EN.
module pu_pass_scheduler #(
  parameter int LAYER_PARAM_WIDTH = 10
`ifdef PU_SCHED_PERF_EN
  , parameter int PERF_WIDTH = 32
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [LAYER_PARAM_WIDTH-1:0] cfg_ic,
  input  logic [LAYER_PARAM_WIDTH-1:0] cfg_oc,
  output logic                         pass_start,
  output logic [LAYER_PARAM_WIDTH-1:0] pass_ic,
  output logic [LAYER_PARAM_WIDTH-1:0] pass_oc,
  output logic                         pass_accumulate,
  output logic                         pass_last_ic,
  input  logic                         pass_done,
  output logic                         wb_req,
  input  logic                         wb_ack,
  output logic                         busy,
  output logic                         layer_done
`ifdef PU_SCHED_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0]        perf_busy_cycles,
  output logic [PERF_WIDTH-1:0]        perf_wb_stall_cycles
`endif
);

  localparam int W = LAYER_PARAM_WIDTH;
  localparam logic [W-1:0] ONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_PASS,
    WRITEBACK,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   ic_q, ic_d;
  logic [W-1:0]   oc_q, oc_d;
  logic [W-1:0]   cic_q, cic_d;
  logic [W-1:0]   coc_q, coc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ic_q    <= '0;
      oc_q    <= '0;
      cic_q   <= '0;
      coc_q   <= '0;
    end else begin
      state_q <= state_d;
      ic_q    <= ic_d;
      oc_q    <= oc_d;
      cic_q   <= cic_d;
      coc_q   <= coc_d;
    end
  end

  // Only the event owned by the current state is acted on, so
  // stray pass_done/wb_ack pulses fall through unchanged.
  always_comb begin
    state_d = state_q;
    ic_d    = ic_q;
    oc_d    = oc_q;
    cic_d   = cic_q;
    coc_d   = coc_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          cic_d   = cfg_ic;
          coc_d   = cfg_oc;
          ic_d    = '0;
          oc_d    = '0;
          state_d = START;
        end
      end
      START: state_d = WAIT_PASS;
      WAIT_PASS: begin
        if (pass_done) begin
          if (ic_q == cic_q) begin
            state_d = WRITEBACK;
          end else begin
            ic_d    = ic_q + ONE;
            state_d = START;
          end
        end
      end
      WRITEBACK: begin
        if (wb_ack) begin
          if (oc_q == coc_q) begin
            state_d = DONE;
          end else begin
            oc_d    = oc_q + ONE;
            ic_d    = '0;
            state_d = START;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cfg_ready       = (state_q == IDLE);
  assign pass_start      = (state_q == START);
  assign wb_req          = (state_q == WRITEBACK);
  assign layer_done      = (state_q == DONE);
  assign busy            = (state_q != IDLE);
  assign pass_ic         = ic_q;
  assign pass_oc         = oc_q;
  assign pass_accumulate = (ic_q != '0);
  assign pass_last_ic    = (ic_q == cic_q);

`ifdef PU_SCHED_PERF_EN
  logic [PERF_WIDTH-1:0] pbusy_q;
  logic [PERF_WIDTH-1:0] pstall_q;
  logic                  accept;

  assign accept = cfg_ready & cfg_valid;

  // Saturating counters; acceptance happens in IDLE where
  // neither counter can increment, so clear never races an add.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
    end else if (accept) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
    end else begin
      if (busy && !(&pbusy_q)) begin
        pbusy_q <= pbusy_q + 1'b1;
      end
      if (wb_req && !wb_ack && !(&pstall_q)) begin
        pstall_q <= pstall_q + 1'b1;
      end
    end
  end

  assign perf_busy_cycles     = pbusy_q;
  assign perf_wb_stall_cycles = pstall_q;
`endif

endmodule

// File: doc/pu_pass_scheduler.md
# pu_pass_scheduler

Layer-level scheduler sitting between the PU_controller configuration path and the PU/vectorgen datapath. It accepts one layer descriptor (input/output channel counts in the config ROM's minus-one encoding) and runs the nested output-channel / input-channel pass loop in hardware: it issues one PU pass per (oc, ic) pair, flags accumulation, and requests an output writeback after the last input channel of each output channel. It signals layer completion back to the controller.

## Interface
- LAYER_PARAM_WIDTH, 10, width of channel counts and loop indices
- PERF_WIDTH, 32, width of performance counters (used only with PU_SCHED_PERF_EN)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- cfg_valid  in  1  layer descriptor valid
- cfg_ready  out  1  scheduler idle, can accept descriptor
- cfg_ic  in  LAYER_PARAM_WIDTH  input channels minus one
- cfg_oc  in  LAYER_PARAM_WIDTH  output channels minus one
- pass_start  out  1  one-cycle pulse, start one PU pass
- pass_ic  out  LAYER_PARAM_WIDTH  input channel of current pass
- pass_oc  out  LAYER_PARAM_WIDTH  output channel of current pass
- pass_accumulate  out  1  1 = add to partial sums, 0 = overwrite (ic == 0)
- pass_last_ic  out  1  current pass is ic == cfg_ic
- pass_done  in  1  one-cycle pulse, PU pass finished
- wb_req  out  1  level, request writeback of pass_oc slice
- wb_ack  in  1  one-cycle pulse, writeback complete
- busy  out  1  descriptor accepted, layer not finished
- layer_done  out  1  one-cycle pulse, layer finished
- perf_busy_cycles  out  PERF_WIDTH  (PU_SCHED_PERF_EN only)
- perf_wb_stall_cycles  out  PERF_WIDTH  (PU_SCHED_PERF_EN only)

## Operation
- States: IDLE, START, WAIT_PASS, WRITEBACK, DONE.
- IDLE: cfg_ready = 1. On cfg_valid & cfg_ready, latch cfg_ic/cfg_oc, clear ic/oc counters, go START.
- START: pass_start = 1 for exactly this cycle; go WAIT_PASS.
- WAIT_PASS: on pass_done: if ic == cfg_ic_latched, go WRITEBACK; else ic += 1, go START.
- WRITEBACK: wb_req = 1. On wb_ack: if oc == cfg_oc_latched, go DONE; else oc += 1, ic = 0, go START.
- DONE: layer_done = 1 for this cycle; go IDLE.
- pass_ic/pass_oc reflect the counters and remain stable from START until the counter update; pass_accumulate = (ic != 0); pass_last_ic = (ic == cfg_ic_latched).
- busy = 1 in START, WAIT_PASS, WRITEBACK, DONE.
- Total passes = (cfg_ic+1)*(cfg_oc+1); total writebacks = cfg_oc+1.
- cfg_ic = cfg_oc = 0 is legal: one pass, one writeback.
- Counters compare against latched values only; cfg_* changes while busy are ignored.
- pass_done outside WAIT_PASS and wb_ack outside WRITEBACK are ignored (no state or counter change).
- pass_done and wb_ack asserted together in WAIT_PASS: only pass_done is acted on.
- Counters never exceed the latched limit; no wrap-around occurs.

## Timing
- Reset (reset low, asynchronous): state IDLE, counters 0, cfg_ready 1, pass_start 0, pass_ic 0, pass_oc 0, pass_accumulate 0, pass_last_ic 1, wb_req 0, busy 0, layer_done 0, perf counters 0.
- Reset asserted mid-layer aborts immediately; no layer_done is produced.
- Descriptor accepted at cycle N -> pass_start at N+1.
- pass_done at cycle M (non-last ic) -> next pass_start at M+1.
- pass_done at cycle M (last ic) -> wb_req high from M+1 until the wb_ack cycle inclusive.
- wb_ack at cycle W (non-last oc) -> pass_start at W+1; (last oc) -> layer_done at W+1, cfg_ready at W+2.
- All outputs registered-state decodes; no combinational path from inputs to outputs.

## Configuration
- PU_SCHED_PERF_EN defined: perf_busy_cycles increments every cycle busy = 1; perf_wb_stall_cycles increments every cycle in WRITEBACK without wb_ack. Both clear on descriptor acceptance and on reset, saturate at all-ones, and hold after layer_done.
- Undefined: both counters and their ports are absent; scheduling behaviour is identical.

## Test plan
- cfg_ic=0, cfg_oc=0, pass_done 5 cycles after start, wb_ack 3 cycles after wb_req -> 1 pass_start (accumulate 0, last_ic 1), 1 wb_req, layer_done 1 cycle after wb_ack.
- cfg_ic=2, cfg_oc=1 -> 6 pass_starts in order (oc,ic) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); accumulate 0 only at ic 0; 2 writebacks after ic 2.
- Spurious pass_done in IDLE/WRITEBACK and wb_ack in WAIT_PASS -> no state change; pass count unchanged; cfg_* toggled while busy ignored.
- pass_done and wb_ack in same cycle in WAIT_PASS at ic=cfg_ic -> enters WRITEBACK, wb_req stays high until a later wb_ack.
- Reset low during WAIT_PASS of pass (1,1) with cfg_ic=2, cfg_oc=3 -> all outputs at reset values immediately, no layer_done; new descriptor accepted afterwards starts at (0,0).
- With PU_SCHED_PERF_EN: cfg_ic=0, cfg_oc=0, pass_done 4 cycles after pass_start, wb_ack 6 cycles after wb_req rises -> perf_wb_stall_cycles = 6, perf_busy_cycles = 13.
